// File: rtl/pht_update_unit.sv
// PHT write-side producer: turns up to two branch resolutions per cycle into
// saturating-counter updates, queues them, and drains one PHT write per cycle.
module pht_update_unit #(
    parameter int ADDR_W  = 10,
    parameter int STATE_W = 3,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd0_valid,
    input  logic [ADDR_W-1:0]           upd0_addr,
    input  logic [STATE_W-1:0]          upd0_state,
    input  logic                        upd0_taken,
    input  logic                        upd1_valid,
    input  logic [ADDR_W-1:0]           upd1_addr,
    input  logic [STATE_W-1:0]          upd1_state,
    input  logic                        upd1_taken,
    output logic                        upd_ready,
    output logic [ADDR_W+STATE_W:0]     w_obus,
    output logic [$clog2(DEPTH):0]      pending_cnt,
    output logic [7:0]                  drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [STATE_W-1:0] MAX_STATE = {STATE_W{1'b1}};

    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [STATE_W-1:0] ns_mem   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, wr_ptr1;
    logic [CNT_W-1:0]   count, count_next;

    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [STATE_W-1:0] w_data;

    logic               push0, push1, pop;
    logic [STATE_W-1:0] base0, base1, ns0, ns1;
    logic [PTR_W-1:0]   idx;
    logic [8:0]         drop_sum;

    function automatic logic [STATE_W-1:0] next_state(input logic [STATE_W-1:0] base,
                                                      input logic taken);
        if (taken)
            return (base == MAX_STATE) ? MAX_STATE : base + 1'b1;
        else
            return (base == '0) ? '0 : base - 1'b1;
    endfunction

    assign upd_ready   = (count <= CNT_W'(DEPTH - 2));
    assign push0       = upd0_valid & upd_ready;
    assign push1       = upd1_valid & upd_ready;
    assign pop         = (count != '0);
    assign wr_ptr1     = wr_ptr + PTR_W'(push0);
    assign count_next  = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    assign w_obus      = {w_we, w_addr, w_data};
    assign pending_cnt = count;
    assign drop_sum    = {1'b0, drop_cnt} + 9'(upd0_valid) + 9'(upd1_valid);

    // Base selection: later (younger) FIFO matches override earlier ones and the
    // write bus; an older same-cycle slot0 beats everything for slot1.
    always_comb begin
        base0 = upd0_state;
        base1 = upd1_state;
        idx   = '0;
        if (w_we && (w_addr == upd0_addr)) base0 = w_data;
        if (w_we && (w_addr == upd1_addr)) base1 = w_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (addr_mem[idx] == upd0_addr) base0 = ns_mem[idx];
                if (addr_mem[idx] == upd1_addr) base1 = ns_mem[idx];
            end
        end
        ns0 = next_state(base0, upd0_taken);
        if (push0 && (upd0_addr == upd1_addr)) base1 = ns0;
        ns1 = next_state(base1, upd1_taken);
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push0) begin
            addr_mem[wr_ptr] <= upd0_addr;
            ns_mem[wr_ptr]   <= ns0;
        end
        if (push1) begin
            addr_mem[wr_ptr1] <= upd1_addr;
            ns_mem[wr_ptr1]   <= ns1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            w_we     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            drop_cnt <= '0;
        end else begin
            count  <= count_next;
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            if (pop) begin
                w_we   <= 1'b1;
                w_addr <= addr_mem[rd_ptr];
                w_data <= ns_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                w_we <= 1'b0;
            end
            if (!upd_ready)
                drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_pht_update_unit.sv
// Directed bench for pht_update_unit: a per-cycle vector table plus hand
// sequences for backpressure, reset mid-drain and drop-counter saturation.
module tb_pht_update_unit;

    localparam int ADDR_W  = 10;
    localparam int STATE_W = 3;
    localparam int DEPTH   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     upd0_valid, upd0_taken, upd1_valid, upd1_taken;
    logic [ADDR_W-1:0]        upd0_addr, upd1_addr;
    logic [STATE_W-1:0]       upd0_state, upd1_state;
    logic                     upd_ready;
    logic [ADDR_W+STATE_W:0]  w_obus;
    logic [$clog2(DEPTH):0]   pending_cnt;
    logic [7:0]               drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pht_update_unit #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .upd0_valid(upd0_valid), .upd0_addr(upd0_addr), .upd0_state(upd0_state), .upd0_taken(upd0_taken),
        .upd1_valid(upd1_valid), .upd1_addr(upd1_addr), .upd1_state(upd1_state), .upd1_taken(upd1_taken),
        .upd_ready(upd_ready), .w_obus(w_obus), .pending_cnt(pending_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v0; int a0; int s0; logic t0;
        logic v1; int a1; int s1; logic t1;
        logic we; int wa; int wd; int pend; int drop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v0, input int a0, input int s0, input logic t0,
                       input logic v1, input int a1, input int s1, input logic t1,
                       input logic we, input int wa, input int wd, input int pend, input int drop);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.s0 = s0; v.t0 = t0;
        v.v1 = v1; v.a1 = a1; v.s1 = s1; v.t1 = t1;
        v.we = we; v.wa = wa; v.wd = wd; v.pend = pend; v.drop = drop;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic v0, input int a0, input int s0, input logic t0,
                         input logic v1, input int a1, input int s1, input logic t1);
        @(negedge clk);
        upd0_valid = v0; upd0_addr = ADDR_W'(a0); upd0_state = STATE_W'(s0); upd0_taken = t0;
        upd1_valid = v1; upd1_addr = ADDR_W'(a1); upd1_state = STATE_W'(s1); upd1_taken = t1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic we, input int wa, input int wd);
        check({tag, " we"},    int'(w_obus[ADDR_W+STATE_W]), int'(we));
        check({tag, " waddr"}, int'(w_obus[ADDR_W+STATE_W-1:STATE_W]), wa);
        check({tag, " wdata"}, int'(w_obus[STATE_W-1:0]), wd);
    endtask

    initial begin
        // Single record, saturation, dual same-addr, FIFO/bus forwarding, slot1-only,
        // youngest-entry priority and a single-record drop, one row per clock edge.
        add(1,'h05,3,1, 0,0,0,0,   0,'h00,0, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h05,4, 0,0);
        add(0,0,0,0,    0,0,0,0,   0,'h05,4, 0,0);
        add(1,'h31,7,1, 0,0,0,0,   0,'h05,4, 1,0);
        add(1,'h32,0,0, 0,0,0,0,   1,'h31,7, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h32,0, 0,0);
        add(1,'h10,2,1, 1,'h10,2,1, 0,'h32,0, 2,0);
        add(0,0,0,0,    0,0,0,0,   1,'h10,3, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h10,4, 0,0);
        add(1,'h22,5,0, 0,0,0,0,   0,'h10,4, 1,0);
        add(1,'h22,5,0, 0,0,0,0,   1,'h22,4, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h22,3, 0,0);
        add(1,'h22,5,1, 0,0,0,0,   0,'h22,3, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h22,4, 0,0);
        add(0,0,0,0,    1,'h40,1,0, 0,'h22,4, 1,0);
        add(0,0,0,0,    0,0,0,0,   1,'h40,0, 0,0);
        add(1,'h50,2,1, 1,'h51,6,0, 0,'h40,0, 2,0);
        add(1,'h50,6,1, 1,'h50,0,1, 1,'h50,3, 3,0);
        add(1,'h50,0,0, 0,0,0,0,   1,'h51,5, 2,1);
        add(1,'h50,0,0, 0,0,0,0,   1,'h50,4, 2,1);
        add(0,0,0,0,    0,0,0,0,   1,'h50,5, 1,1);
        add(0,0,0,0,    0,0,0,0,   1,'h50,4, 0,1);
        add(0,0,0,0,    0,0,0,0,   0,'h50,4, 0,1);

        rst = 1'b1;
        upd0_valid = 0; upd0_addr = '0; upd0_state = '0; upd0_taken = 0;
        upd1_valid = 0; upd1_addr = '0; upd1_state = '0; upd1_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        check_bus("reset", 0, 0, 0);
        check("reset pending", int'(pending_cnt), 0);
        check("reset ready", int'(upd_ready), 1);
        check("reset drop", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            cycle(vq[k].v0, vq[k].a0, vq[k].s0, vq[k].t0, vq[k].v1, vq[k].a1, vq[k].s1, vq[k].t1);
            check_bus(tag, vq[k].we, vq[k].wa, vq[k].wd);
            check({tag, " pending"}, int'(pending_cnt), vq[k].pend);
            check({tag, " ready"}, int'(upd_ready), (vq[k].pend <= DEPTH - 2) ? 1 : 0);
            check({tag, " drop"}, int'(drop_cnt), vq[k].drop);
        end

        // Backpressure: fill to DEPTH-1 two at a time, then both records drop.
        cycle(1,'h60,1,1, 1,'h61,1,1);
        check("bp fill1 pending", int'(pending_cnt), 2);
        cycle(1,'h62,1,1, 1,'h63,1,1);
        check("bp fill2 pending", int'(pending_cnt), 3);
        check("bp fill2 ready", int'(upd_ready), 0);
        check_bus("bp fill2", 1, 'h60, 2);
        cycle(1,'h70,4,1, 1,'h71,4,1);
        check("bp drop cnt", int'(drop_cnt), 3);
        check("bp drop pending", int'(pending_cnt), 2);
        check("bp ready back", int'(upd_ready), 1);
        check_bus("bp drop", 1, 'h61, 2);

        // Reset with three entries pending: nothing stale may drain afterwards.
        cycle(1,'h64,1,1, 1,'h65,1,1);
        check("pre-rst pending", int'(pending_cnt), 3);
        @(negedge clk);
        upd0_valid = 0; upd1_valid = 0; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid we", int'(w_obus[ADDR_W+STATE_W]), 0);
        check("rst mid pending", int'(pending_cnt), 0);
        check("rst mid drop", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(0,0,0,0, 0,0,0,0);
            check($sformatf("post-rst%0d we", i), int'(w_obus[ADDR_W+STATE_W]), 0);
            check($sformatf("post-rst%0d pending", i), int'(pending_cnt), 0);
        end

        // Continuous dual traffic drops two records every other cycle; counter must stop at 255.
        for (int i = 0; i < 300; i++)
            cycle(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        check("drop saturate", int'(drop_cnt), 255);
        cycle(1,'h01,0,1, 1,'h02,0,1);
        check("drop hold", int'(drop_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
